// File: rtl/multicycle_mem_pkg.sv
// multicycle_mem_pkg
//   Shared constants and the FSM state encoding for the multi-cycle MIPS
//   memory responder (multicycle_mem) and its word array.
package multicycle_mem_pkg;

    localparam int WORD_BYTES = 4;   // bytes per memory word
    localparam int WAIT_W     = 4;   // wait-state counter width (WAIT_CYCLES 0..15)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_word_array.sv
// mem_word_array
//   Word-addressed 32-bit storage with two write ports and one combinational
//   read port. The init (backdoor) port has priority over the datapath port
//   when both write the same word at the same edge.
//
// Ports:
//   clk        in   clock, writes on rising edge
//   init_en    in   backdoor write enable
//   init_addr  in   backdoor word index
//   init_data  in   backdoor write data
//   dp_en      in   datapath write enable
//   dp_addr    in   datapath word index
//   dp_data    in   datapath write data
//   rd_addr    in   read word index
//   rd_data    out  combinational read data
module mem_word_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          init_en,
    input  logic [AW-1:0] init_addr,
    input  logic [31:0]   init_data,
    input  logic          dp_en,
    input  logic [AW-1:0] dp_addr,
    input  logic [31:0]   dp_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // The datapath write is suppressed when init targets the same word so
    // the backdoor value always lands.
    always_ff @(posedge clk) begin
        if (dp_en && !(init_en && (init_addr == dp_addr)))
            mem[dp_addr] <= dp_data;
        if (init_en)
            mem[init_addr] <= init_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/multicycle_mem.sv
// multicycle_mem
//   Unified instruction/data memory responder for the multi-cycle MIPS core.
//   Accepts one read or write per transaction, inserts WAIT_CYCLES wait
//   states, then pulses ready for one cycle with err qualifying the result.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   adr         in   byte address from the datapath
//   wdata       in   write data
//   mem_read    in   read strobe
//   mem_write   in   write strobe
//   rdata       out  read data, held until the next read completes
//   ready       out  one-cycle completion pulse
//   err         out  misaligned / out-of-range / read+write conflict (with ready)
//   init_en     in   backdoor write enable
//   init_waddr  in   backdoor word index
//   init_wdata  in   backdoor write data
module multicycle_mem
    import multicycle_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    adr,
    input  logic [31:0]                    wdata,
    input  logic                           mem_read,
    input  logic                           mem_write,
    output logic [31:0]                    rdata,
    output logic                           ready,
    output logic                           err,
    input  logic                           init_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] init_waddr,
    input  logic [31:0]                    init_wdata
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        WAIT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    logic [1:0]        state;
    logic [WAIT_W-1:0] cnt;
    logic [31:0]       req_adr;
    logic [31:0]       req_wdata;
    logic              req_rd;
    logic              req_wr;

    // In IDLE the live inputs describe the request being accepted; with
    // WAIT_CYCLES=0 that request goes straight to DONE, so rdata must be
    // loaded from the live address. Elsewhere the latched copy is used.
    logic [31:0]   cur_adr;
    logic          cur_rd;
    logic          cur_wr;
    logic          cur_ok;
    logic [AW-1:0] cur_idx;
    logic          start;
    logic          to_done;
    logic          dp_en;
    logic [31:0]   arr_rd;

    assign cur_adr = (state == S_IDLE) ? adr       : req_adr;
    assign cur_rd  = (state == S_IDLE) ? mem_read  : req_rd;
    assign cur_wr  = (state == S_IDLE) ? mem_write : req_wr;
    assign cur_ok  = (cur_adr[1:0] == 2'b00) && (cur_adr[31:2] < 30'(DEPTH_WORDS));
    assign cur_idx = cur_adr[AW+1:2];

    assign start   = (state == S_IDLE) && (mem_read || mem_write);
    assign to_done = (start && (WAIT_CYCLES == 0)) ||
                     ((state == S_BUSY) && (cnt == '0));

    assign ready = (state == S_DONE);
    assign err   = ready && (!cur_ok || (cur_rd && cur_wr));

    // Write commits on the edge leaving DONE; a reset on that edge drops it.
    assign dp_en = (state == S_DONE) && cur_wr && cur_ok && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_adr   <= '0;
            req_wdata <= '0;
            req_rd    <= 1'b0;
            req_wr    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        req_adr   <= adr;
                        req_wdata <= wdata;
                        req_rd    <= mem_read;
                        req_wr    <= mem_write;
                        if (WAIT_CYCLES > 0) begin
                            state <= S_BUSY;
                            cnt   <= WAIT_LOAD;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt == '0) state <= S_DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // rdata only changes when a pure read enters DONE; writes (including
    // read+write conflicts) leave it alone. Bad addresses read as zero.
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (to_done && cur_rd && !cur_wr)
            rdata <= cur_ok ? arr_rd : 32'h0;
    end

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk       (clk),
        .init_en   (init_en),
        .init_addr (init_waddr),
        .init_data (init_wdata),
        .dp_en     (dp_en),
        .dp_addr   (req_adr[AW+1:2]),
        .dp_data   (req_wdata),
        .rd_addr   (cur_idx),
        .rd_data   (arr_rd)
    );

endmodule

// File: tb/tb_multicycle_mem.sv
// tb_multicycle_mem
//   Three responders (WAIT_CYCLES 0, 3, 5) driven by directed and random
//   transactions; expectations come from a word-array model and the
//   handshake latency rule (ready WAIT_CYCLES+1 cycles after the request).
module tb_multicycle_mem;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int N     = 3;

    int wait_tab [N] = '{0, 3, 5};

    logic          clk;
    logic          rst        [N];
    logic [31:0]   adr        [N];
    logic [31:0]   wdata      [N];
    logic          mem_read   [N];
    logic          mem_write  [N];
    logic [31:0]   rdata      [N];
    logic          ready      [N];
    logic          err        [N];
    logic          init_en    [N];
    logic [AW-1:0] init_waddr [N];
    logic [31:0]   init_wdata [N];

    logic [31:0] mdl [N][DEPTH];
    logic [31:0] mrd [N];

    int vectors;
    int miscompares;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
        multicycle_mem #(
            .DEPTH_WORDS (DEPTH),
            .WAIT_CYCLES (W)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .adr        (adr[g]),
            .wdata      (wdata[g]),
            .mem_read   (mem_read[g]),
            .mem_write  (mem_write[g]),
            .rdata      (rdata[g]),
            .ready      (ready[g]),
            .err        (err[g]),
            .init_en    (init_en[g]),
            .init_waddr (init_waddr[g]),
            .init_wdata (init_wdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction. Entered at a negedge with the DUT idle; returns at the
    // negedge of the cycle after ready, so calls chain back to back.
    task automatic do_access(input int d, input bit rd, input bit wr,
                             input logic [31:0] a, input logic [31:0] wd,
                             input bit coll, input logic [31:0] cwd);
        int lat;
        bit seen;
        bit ok;
        bit exp_err;
        int idx;
        ok      = (a[1:0] == 2'b00) && (a[31:2] < 30'(DEPTH));
        exp_err = !ok || (rd && wr);
        idx     = ok ? int'(a[31:2]) : 0;
        if (wr) begin
            if (ok) mdl[d][idx] = wd;
        end else if (rd) begin
            mrd[d] = ok ? mdl[d][idx] : 32'h0;
        end
        adr[d] = a; wdata[d] = wd; mem_read[d] = rd; mem_write[d] = wr;
        lat = 0; seen = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ready[d]) seen = 1;
        end
        vectors++;
        if (lat !== wait_tab[d] + 1) begin
            miscompares++;
            $display("FAIL latency d%0d adr=%h: got %0d cycles want %0d", d, a, lat, wait_tab[d] + 1);
        end
        vectors++;
        if (err[d] !== exp_err) begin
            miscompares++;
            $display("FAIL err d%0d adr=%h rd=%0b wr=%0b: got %b want %b", d, a, rd, wr, err[d], exp_err);
        end
        vectors++;
        if (rdata[d] !== mrd[d]) begin
            miscompares++;
            $display("FAIL rdata d%0d adr=%h: got %h want %h", d, a, rdata[d], mrd[d]);
        end
        mem_read[d] = 1'b0; mem_write[d] = 1'b0;
        if (coll) begin
            init_en[d] = 1'b1; init_waddr[d] = a[AW+1:2]; init_wdata[d] = cwd;
            mdl[d][idx] = cwd;
        end
        @(negedge clk);
        init_en[d] = 1'b0;
        vectors++;
        if (ready[d] !== 1'b0 || err[d] !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse d%0d: got ready=%b err=%b want 0 0", d, ready[d], err[d]);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < N; d++) begin
            rst[d] = 1'b1; adr[d] = '0; wdata[d] = '0;
            mem_read[d] = 1'b0; mem_write[d] = 1'b0; init_en[d] = 1'b1;
            mrd[d] = 32'h0;
        end
        // Load every word through the backdoor while held in reset.
        for (int i = 0; i < DEPTH; i++) begin
            for (int d = 0; d < N; d++) begin
                init_waddr[d] = AW'(i);
                init_wdata[d] = $urandom;
                mdl[d][i]     = init_wdata[d];
            end
            @(negedge clk);
        end
        for (int d = 0; d < N; d++) init_en[d] = 1'b0;
        for (int d = 0; d < N; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            vectors++;
            if (ready[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset d%0d: got ready=%b err=%b rdata=%h want 0 0 0", d, ready[d], err[d], rdata[d]);
            end
        end
    endtask

    task automatic test_read_basic();
        init_en[0] = 1'b1; init_waddr[0] = AW'(3); init_wdata[0] = 32'h2002_0005;
        mdl[0][3] = 32'h2002_0005;
        @(negedge clk);
        init_en[0] = 1'b0;
        do_access(0, 1, 0, 32'h0000_000C, 32'h0, 0, 32'h0);
    endtask

    task automatic test_write_read();
        do_access(1, 1, 0, 32'h0000_0004, 32'h0, 0, 32'h0);
        do_access(1, 0, 1, 32'h0000_0040, 32'hDEAD_BEEF, 0, 32'h0);
        do_access(1, 1, 0, 32'h0000_0040, 32'h0, 0, 32'h0);
        vectors++;
        if (rdata[1] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL write_read: got %h want %h", rdata[1], 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_errors();
        for (int d = 0; d < N; d++) begin
            do_access(d, 1, 0, 32'h0000_0042, 32'h0, 0, 32'h0);
            do_access(d, 0, 1, 32'(DEPTH * 4), 32'h1234_5678, 0, 32'h0);
            do_access(d, 0, 1, 32'h0000_0046, 32'h8765_4321, 0, 32'h0);
            do_access(d, 1, 0, 32'h0000_0000, 32'h0, 0, 32'h0);
            do_access(d, 1, 0, 32'h0000_0044, 32'h0, 0, 32'h0);
            do_access(d, 1, 0, 32'hFFFF_FFFC, 32'h0, 0, 32'h0);
        end
    endtask

    task automatic test_conflict();
        for (int d = 0; d < N; d++) begin
            do_access(d, 1, 1, 32'h0000_0010, 32'h0000_0001, 0, 32'h0);
            do_access(d, 1, 0, 32'h0000_0010, 32'h0, 0, 32'h0);
        end
    endtask

    task automatic test_reset_mid_busy();
        bit saw;
        adr[2] = 32'h0000_0020; wdata[2] = ~mdl[2][8];
        mem_write[2] = 1'b1;
        @(negedge clk);            // first BUSY cycle
        @(negedge clk);            // second BUSY cycle
        rst[2] = 1'b1; mem_write[2] = 1'b0;
        @(negedge clk);
        rst[2] = 1'b0;
        mrd[2] = 32'h0;
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            if (ready[2]) saw = 1;
            @(negedge clk);
        end
        vectors++;
        if (saw !== 1'b0 || rdata[2] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_busy: got ready_seen=%b rdata=%h want 0 0", saw, rdata[2]);
        end
        do_access(2, 1, 0, 32'h0000_0020, 32'h0, 0, 32'h0);
    endtask

    task automatic test_init_collision();
        for (int d = 0; d < N; d++) begin
            do_access(d, 0, 1, 32'h0000_0008, 32'h5555_5555, 1, 32'hAAAA_AAAA);
            do_access(d, 1, 0, 32'h0000_0008, 32'h0, 0, 32'h0);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int r;
        int op;
        for (int d = 0; d < N; d++) begin
            for (int k = 0; k < 30; k++) begin
                r = $urandom_range(0, 9);
                if (r == 0)
                    a = {22'h0, 8'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
                else if (r == 1)
                    a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000) * 4);
                else
                    a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                op = $urandom_range(0, 9);
                do_access(d, (op < 5) || (op == 9), op >= 5, a, $urandom, 0, 32'h0);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_read_basic();
        test_write_read();
        test_errors();
        test_conflict();
        test_reset_mid_busy();
        test_init_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_mem.md
# multicycle_mem

Unified instruction/data memory responder for the multi-cycle MIPS core. It is the far end of the datapath's memory interface: it accepts the byte address and write data from the datapath and read/write strobes from the controller, and returns read data with a `ready` handshake after a configurable number of wait states. A bench-only init port loads programs without going through the core.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; word index = `adr[31:2]`.
- `WAIT_CYCLES`, 0: extra cycles inserted between accept and completion; legal range 0..15.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `adr`  in  32  byte address from the datapath (IorD-selected PC or ALU result).
- `wdata`  in  32  write data (datapath B register).
- `mem_read`  in  1  read request from controller.
- `mem_write`  in  1  write request from controller.
- `rdata`  out  32  read data to the datapath (feeds IR and MDR).
- `ready`  out  1  one-cycle completion pulse; controller advances on it.
- `err`  out  1  qualified by `ready`: misaligned, out-of-range or read+write conflict.
- `init_en`  in  1  bench backdoor write enable.
- `init_waddr`  in  log2(DEPTH_WORDS)  backdoor word index.
- `init_wdata`  in  32  backdoor write data.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if `mem_read | mem_write` at an edge, latch `adr`, `wdata`, op into request registers; go to BUSY if `WAIT_CYCLES>0` (load wait counter with `WAIT_CYCLES-1`), else to DONE.
- BUSY: counter decrements each cycle; at count 0 go to DONE. Strobe/address changes during BUSY are ignored (latched request used).
- Entry into DONE: for a read, `rdata` register loads `mem[latched_adr[31:2]]`; for a write, `rdata` keeps its old value.
- DONE: `ready=1`, `err` valid; unconditional return to IDLE. A write commits to the array at the edge leaving DONE.
- Errors (checked on latched request): `adr[1:0]!=0` or `adr[31:2]>=DEPTH_WORDS` -> `err=1`, write discarded, read returns `rdata=0`. Both `mem_read` and `mem_write` high -> `err=1`, treated as a write (write wins).
- Init port: writes `mem[init_waddr]=init_wdata` at any edge, any state; if a datapath write commits to the same word at the same edge, init wins.
- Array contents are not reset.

## Timing
- Reset values: state IDLE, `rdata=0`, `ready=0`, `err=0`, counter 0, request registers 0.
- Latency: request asserted in cycle n (FSM in IDLE) -> `ready` high in cycle n+1+`WAIT_CYCLES`, exactly one cycle.
- `rdata` valid in the `ready` cycle and held until the next read completes.
- Controller must hold the strobe through the `ready` cycle and change it at the same edge; a strobe still high in the cycle after `ready` is a new request.
- Max throughput: one access per `WAIT_CYCLES+2` cycles.
- `rst` mid-operation (BUSY or DONE): return to IDLE next cycle, `ready`/`err` low, pending write discarded, array untouched.
- `err` is 0 whenever `ready` is 0.

## Structure
- Package `multicycle_mem_pkg`: state enum (IDLE/BUSY/DONE), `WORD_BYTES=4`, `WAIT_W=4` counter width.
- Sub-module `mem_word_array`: two-write-port (init priority), one combinational read port array; the FSM/handshake stays in `multicycle_mem`.

## Test plan
- `WAIT_CYCLES=0`, init word 3 = 32'h2002_0005, `mem_read`, `adr=32'h0C` in cycle 0 -> `ready` cycle 1, `rdata=32'h2002_0005`, `err=0`.
- `WAIT_CYCLES=3`, `mem_write`, `adr=32'h40`, `wdata=32'hDEAD_BEEF`, then read `32'h40` -> write `ready` in cycle 4; read returns 32'hDEAD_BEEF, `rdata` unchanged by the write.
- `adr=32'h42` read, and `adr=DEPTH_WORDS*4` write -> `ready` with `err=1`; read `rdata=0`; target words unchanged.
- `mem_read` and `mem_write` both high, `adr=32'h10`, `wdata=32'h1` -> `err=1`, word 4 becomes 32'h1.
- `WAIT_CYCLES=5`, `rst` pulsed in second BUSY cycle of write to `32'h20` -> no `ready`, word 8 unchanged, next read completes normally.
- Init write and datapath write to word 2 on the same edge with 32'hAAAA_AAAA vs 32'h5555_5555 -> word 2 = 32'hAAAA_AAAA.
